// File: rtl/record_word_fifo.sv
// rtl/record_word_fifo.sv - record-in/word-out FIFO toward the host link; optional RECORD_WORD_FIFO_MSB_FIRST_EN reverses word order
module record_word_fifo #(
    parameter int WORD_SIZE    = 8,
    parameter int RECORD_WORDS = 16,
    parameter int SLOTS        = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       write_en,
    input  logic [WORD_SIZE*RECORD_WORDS-1:0]          data_in,
    input  logic                                       read_en,
    output logic [WORD_SIZE-1:0]                       data_out,
    output logic [$clog2(SLOTS*RECORD_WORDS):0]        size,
    output logic                                       full,
    output logic                                       empty,
    output logic                                       overflow,
    output logic                                       underflow
);

    localparam int RECORD_SIZE_BITS = WORD_SIZE * RECORD_WORDS;
    localparam int STORAGE_SIZE     = SLOTS * RECORD_WORDS;
    localparam int SLOT_BITS        = $clog2(SLOTS);
    localparam int PTR_W            = SLOT_BITS + 1;
    localparam int IDX_W            = $clog2(RECORD_WORDS);
    localparam int SIZE_W           = $clog2(STORAGE_SIZE) + 1;

    localparam logic [PTR_W-1:0]  SLOTS_P     = PTR_W'(SLOTS);
    localparam logic [IDX_W-1:0]  LAST_WORD   = IDX_W'(RECORD_WORDS - 1);
    localparam logic [SIZE_W-1:0] REC_WORDS_S = SIZE_W'(RECORD_WORDS);

    // Record storage; deliberately not reset, only the pointers define validity.
    logic [RECORD_SIZE_BITS-1:0] mem [SLOTS];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] word_idx;

    logic [PTR_W-1:0]            rec_count;
    logic                        do_write;
    logic                        do_read;
    logic                        last_word;
    logic [RECORD_SIZE_BITS-1:0] head;
    logic [WORD_SIZE-1:0]        head_words [RECORD_WORDS];
    logic [IDX_W-1:0]            sel;

    // Occupancy, flags and handshake qualification from registered state only.
    always_comb begin
        rec_count = wr_ptr - rd_ptr;
        full      = (rec_count == SLOTS_P);
        empty     = (wr_ptr == rd_ptr);
        size      = (SIZE_W'(rec_count) * REC_WORDS_S) - SIZE_W'(word_idx);
        do_write  = write_en && !full;
        do_read   = read_en && !empty;
        last_word = (word_idx == LAST_WORD);
    end

    // Split the head record into words and pick the current one (show-ahead).
    always_comb begin
        head = mem[rd_ptr[SLOT_BITS-1:0]];
        for (int i = 0; i < RECORD_WORDS; i++) begin
            head_words[i] = head[i*WORD_SIZE +: WORD_SIZE];
        end
`ifdef RECORD_WORD_FIFO_MSB_FIRST_EN
        // RECORD_WORDS is a power of two, so ~idx == RECORD_WORDS-1-idx.
        sel = ~word_idx;
`else
        sel = word_idx;
`endif
        data_out = empty ? '0 : head_words[sel];
    end

    // Record write into the slot addressed by the low write-pointer bits.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr[SLOT_BITS-1:0]] <= data_in;
        end
    end

    // Pointer, word index and sticky error flag updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            word_idx  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_read) begin
                if (last_word) begin
                    word_idx <= '0;
                    rd_ptr   <= rd_ptr + PTR_W'(1);
                end else begin
                    word_idx <= word_idx + IDX_W'(1);
                end
            end
            if (write_en && full) begin
                overflow <= 1'b1;
            end
            if (read_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
